fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have one parameter: RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 The block SHALL have these ports, one per line as name / direction / width / meaning:
- CLK  in  1  clock; all state updates on its rising edge
- RST  in  1  synchronous active-high reset
- ihit  in  1  instruction memory returns imemload this cycle
- imemload  in  32  instruction word at imemaddr
- imemREN  out  1  instruction read request
- imemaddr  out  32  fetch address (current PC)
- redirect  in  1  taken branch or jump from a later stage; flushes fetch
- redirect_pc  in  32  target PC for redirect
- halt  in  1  stop fetching
- stall  in  1  fetch/decode latch cannot accept this cycle
- valid_out  out  1  head entry presented to fetch/decode latch
- fetch_instr_out  out  32  head instruction
- pc_out  out  32  PC of head instruction
- pc4_out  out  32  pc_out + 4
- next_pc_out  out  32  predicted next PC

Function
REQ-004 The block SHALL hold the PC register, a sticky halted flag, and a 2-entry FIFO of {instr, pc}, plus a 2-bit count (0..2).
REQ-005 imemREN SHALL be 1 iff halted==0 AND count<2 AND redirect==0.
REQ-006 imemaddr SHALL equal the PC register combinationally.
REQ-007 Push: when imemREN && ihit, the block SHALL write {imemload, PC} at tail and set PC <= PC+4 that edge.
REQ-008 PC arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC + 4 SHALL wrap to 32'h0.
REQ-009 Pop: when valid_out && !stall, the block SHALL advance head; push and pop in the same cycle SHALL leave count unchanged.
REQ-010 valid_out SHALL be (count!=0); fetch_instr_out/pc_out SHALL reflect head entry combinationally (zero-latency from FIFO).
REQ-011 pc4_out and next_pc_out SHALL both equal pc_out+4 (sequential prediction; no branch predictor).
REQ-012 When count==0, fetch_instr_out, pc_out, pc4_out, next_pc_out SHALL be 32'h0.
REQ-013 Fetch latency: an ihit in cycle N SHALL make the instruction visible on valid_out in cycle N+1.
REQ-014 With stall held, the FIFO SHALL fill to 2 then deassert imemREN; head outputs SHALL remain stable.
REQ-015 Redirect SHALL take priority over every other event: on an edge with redirect==1, count <= 0, head/tail <= 0, PC <= {redirect_pc[31:2], 2'b00}; any same-cycle ihit data SHALL be discarded and any same-cycle pop ignored.
REQ-016 valid_out SHALL be 0 in the cycle after a redirect; fetch SHALL resume from the new PC that cycle.
REQ-017 halt==1 at an edge SHALL set halted <= 1, and the same-cycle ihit SHALL be discarded; halted SHALL clear only on reset.
REQ-018 While halted, already-buffered entries SHALL still drain under normal pop rules; redirect SHALL still update PC and flush, but no fetch SHALL occur.
REQ-019 Simultaneous redirect and halt SHALL apply both: flush, PC <= target, halted <= 1.
REQ-020 ihit while imemREN==0 SHALL be ignored.

Reset
REQ-021 On an edge with RST==1, PC <= RESET_PC, count <= 0, head <= 0, tail <= 0, halted <= 0; RST SHALL override redirect, halt, and ihit.
REQ-022 During and one cycle after reset the block SHALL drive valid_out=0 and all data outputs 32'h0; imemREN SHALL be 0 while RST==1.
REQ-023 Reset asserted mid-operation with a full FIFO SHALL discard all entries within that one edge.

Verification
REQ-024 The bench SHALL run the streaming case: reset release, ihit=1 every cycle, stall=0 -> pc_out sequence 0x0, 0x4, 0x8 on consecutive cycles from cycle 2; pc4_out = pc_out+4.
REQ-025 The bench SHALL check stall backpressure: stall=1 from the first valid cycle -> count reaches 2, imemREN=0, imemaddr=0x8, pc_out held at 0x0; releasing stall -> 0x0, 0x4, 0x8 delivered in order, none lost or duplicated.
REQ-026 The bench SHALL check redirect: FIFO full (0x0, 0x4), redirect=1 with redirect_pc=0x103 and ihit=1 -> next cycle valid_out=0 and imemaddr=0x100; the next ihit yields pc_out=0x100.
REQ-027 The bench SHALL check halt: halt pulse with one entry buffered -> that entry drains, then imemREN stays 0 forever, valid_out=0; a later redirect to 0x40 sets imemaddr=0x40 with imemREN=0.
REQ-028 The bench SHALL check wrap: RESET_PC=32'hFFFF_FFF8 with ihit streaming -> pc_out sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; pc4_out of FFFF_FFFC equals 0.
REQ-029 The bench SHALL check mid-operation reset: RST=1 with 2 entries buffered and redirect=1 -> next cycle valid_out=0, imemaddr=RESET_PC, halted=0.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: PC register, sticky halt and a 2-entry {instr, pc} buffer
// feeding the fetch/decode latch.
//
// Ports:
//   CLK, RST         clock; synchronous active-high reset
//   ihit, imemload   instruction memory response for imemaddr
//   imemREN          read request
//   imemaddr         fetch address (PC register)
//   redirect         flush request from a later stage
//   redirect_pc      redirect target (word aligned here)
//   halt             sticky stop-fetch request
//   stall            fetch/decode latch cannot accept
//   valid_out        head entry presented
//   fetch_instr_out  head instruction
//   pc_out           head PC
//   pc4_out          pc_out + 4
//   next_pc_out      predicted next PC (sequential)
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  input  logic        stall,
  output logic        valid_out,
  output logic [31:0] fetch_instr_out,
  output logic [31:0] pc_out,
  output logic [31:0] pc4_out,
  output logic [31:0] next_pc_out
);

  logic [31:0] pc_q;
  logic        halted_q;
  logic [31:0] instr_q [2];
  logic [31:0] epc_q   [2];
  logic        head_q;
  logic        tail_q;
  logic [1:0]  count_q;

  logic        live;
  logic        push;
  logic        pop;
  logic [31:0] head_pc4;

  // Outputs read as empty while RST is high, even if the
  // buffer still holds entries until the reset edge.
  assign live = !RST && (count_q != 2'd0);

  assign imemREN = !RST && !halted_q
                && (count_q < 2'd2) && !redirect;
  assign imemaddr = pc_q;

  // A halt edge discards the word returned that cycle.
  assign push = imemREN && ihit && !halt;
  assign pop  = live && !stall;

  assign head_pc4 = epc_q[head_q] + 32'd4;

  assign valid_out       = live;
  assign fetch_instr_out = live ? instr_q[head_q] : 32'h0;
  assign pc_out          = live ? epc_q[head_q] : 32'h0;
  assign pc4_out         = live ? head_pc4 : 32'h0;
  assign next_pc_out     = live ? head_pc4 : 32'h0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
      count_q  <= 2'd0;
    end else if (redirect) begin
      pc_q     <= {redirect_pc[31:2], 2'b00};
      halted_q <= halted_q | halt;
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      halted_q <= halted_q | halt;
      if (push) begin
        pc_q   <= pc_q + 32'd4;
        tail_q <= ~tail_q;
      end
      if (pop) begin
        head_q <= ~head_q;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // push is already low under RST and redirect.
  always_ff @(posedge CLK) begin
    if (push) begin
      instr_q[tail_q] <= imemload;
      epc_q[tail_q]   <= pc_q;
    end
  end

endmodule
